// File: rtl/avmm_req_packer.sv
// Avalon-MM slave front end: serializes read/write commands into header, address
// and (writes only) data words on the s2m request FIFO write port.
package avmm_lvds_bridge_pkg;
  parameter int unsigned MAX_BURST = 16;
endpackage

module avmm_req_packer #(
  parameter int unsigned MAX_BURST = avmm_lvds_bridge_pkg::MAX_BURST,
  parameter int unsigned BCW       = $clog2(MAX_BURST) + 1
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [31:0]     avs_address_i,
  input  logic            avs_read_i,
  input  logic            avs_write_i,
  input  logic [31:0]     avs_writedata_i,
  input  logic [3:0]      avs_byteenable_i,
  input  logic [BCW-1:0]  avs_burstcount_i,
  output logic            avs_waitrequest_o,
  output logic [31:0]     req_data_o,
  output logic            req_wrreq_o,
  input  logic            req_wrfull_i
);

  typedef enum logic [1:0] {IDLE, HDR, ADDR, DATA} state_t;

  state_t          state, state_next;
  logic [31:0]     addr_q;
  logic [3:0]      be_q;
  logic [BCW-1:0]  bc_q;
  logic [BCW-1:0]  beats_left;
  logic            is_write;
  logic            emit;
  logic            beat_ok;
  logic            waitrequest;
  logic [31:0]     word;
  logic [31:0]     data_q;
  logic            wrreq_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (avs_write_i || avs_read_i) state_next = HDR;
      HDR:     if (!req_wrfull_i) state_next = ADDR;
      ADDR:    if (!req_wrfull_i) state_next = is_write ? DATA : IDLE;
      DATA:    if (beat_ok && beats_left == BCW'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A read is accepted in the same cycle its address word goes out; a write
  // is only accepted beat by beat in DATA.
  always_comb begin
    emit        = 1'b0;
    beat_ok     = 1'b0;
    waitrequest = 1'b1;
    word        = '0;
    unique case (state)
      HDR: begin
        emit = !req_wrfull_i;
        word = {is_write, 3'b000, be_q, 8'h00, 16'(bc_q)};
      end
      ADDR: begin
        emit = !req_wrfull_i;
        word = addr_q;
        if (!is_write) waitrequest = req_wrfull_i;
      end
      DATA: begin
        beat_ok     = avs_write_i && !req_wrfull_i;
        emit        = beat_ok;
        word        = avs_writedata_i;
        waitrequest = req_wrfull_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q     <= '0;
      be_q       <= '0;
      bc_q       <= '0;
      is_write   <= 1'b0;
      beats_left <= '0;
      data_q     <= '0;
      wrreq_q    <= 1'b0;
    end else begin
      wrreq_q <= emit;
      if (emit) data_q <= word;
      if (state == IDLE && (avs_write_i || avs_read_i)) begin
        addr_q   <= avs_address_i;
        be_q     <= avs_byteenable_i;
        bc_q     <= avs_burstcount_i;
        is_write <= avs_write_i;
      end
      if (state == ADDR && emit && is_write) beats_left <= bc_q;
      else if (beat_ok)                      beats_left <= beats_left - BCW'(1);
    end
  end

  assign avs_waitrequest_o = waitrequest;
  assign req_data_o        = data_q;
  assign req_wrreq_o       = wrreq_q;

  a_burst_legal: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (state == IDLE && (avs_read_i || avs_write_i)) |->
      (avs_burstcount_i != '0 && 32'(avs_burstcount_i) <= MAX_BURST));

  a_no_read_in_data: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (state == DATA) |-> !avs_read_i);

  a_cmd_stable: assert property (@(posedge clk_i) disable iff (!rstn_i)
    $past(avs_waitrequest_o && (avs_read_i || avs_write_i)) |->
      $stable({avs_read_i, avs_write_i, avs_address_i, avs_writedata_i,
               avs_byteenable_i, avs_burstcount_i}));

endmodule

// File: tb/tb_avmm_req_packer.sv
// Bench for avmm_req_packer: directed commands plus a random command run, with a
// packet-level model whose expected word stream is checked on every FIFO write.
`timescale 1ns/1ps
module tb_avmm_req_packer;
  localparam int unsigned MAXB = 16;
  localparam int unsigned BCW  = 5;
  localparam int          LIMIT = 400;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [31:0]     avs_address = '0;
  logic            avs_read = 1'b0;
  logic            avs_write = 1'b0;
  logic [31:0]     avs_writedata = '0;
  logic [3:0]      avs_byteenable = '0;
  logic [BCW-1:0]  avs_burstcount = '0;
  logic            avs_waitrequest;
  logic [31:0]     req_data;
  logic            req_wrreq;
  logic            req_wrfull = 1'b0;

  always #5 clk = ~clk;

  avmm_req_packer #(.MAX_BURST(MAXB), .BCW(BCW)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .avs_address_i(avs_address), .avs_read_i(avs_read), .avs_write_i(avs_write),
    .avs_writedata_i(avs_writedata), .avs_byteenable_i(avs_byteenable),
    .avs_burstcount_i(avs_burstcount), .avs_waitrequest_o(avs_waitrequest),
    .req_data_o(req_data), .req_wrreq_o(req_wrreq), .req_wrfull_i(req_wrfull)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got[$];
  logic        full_prev = 1'b0;
  int          full_mode = 0;  // 0: never full, 1: full_pat per cycle, 2: random
  logic [31:0] full_pat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hdr_word(input bit w, input logic [3:0] be, input int unsigned bc);
    return (w ? 32'h8000_0000 : 32'h0) + (32'(be) << 24) + bc;
  endfunction

  task automatic set_full(input int c);
    case (full_mode)
      1:       req_wrfull = (c < 32) ? full_pat[c] : 1'b0;
      2:       req_wrfull = ($urandom_range(3) == 0);
      default: req_wrfull = 1'b0;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_wrfull = 1'b0;
    end
  endtask

  always @(posedge clk) full_prev <= req_wrfull;

  always @(negedge clk) begin
    if (rstn && req_wrreq) begin
      got.push_back(req_data);
      check("wrreq_while_full", 32'(full_prev), 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_word: got 0x%08h expected no word", req_data);
      end else begin
        check("stream_word", req_data, exp_q.pop_front());
      end
    end
  end

  // Write master; data beat i carries base+i. abort_after>0 pulses reset after that many beats.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input int unsigned n,
                          input logic [31:0] base, input int gap_pct, input int unsigned abort_after,
                          output int wr_low, output int first_low);
    int unsigned beat = 0;
    int c = 0;
    bit acc;
    wr_low = 0;
    first_low = -1;
    exp_q.push_back(hdr_word(1'b1, be, n));
    exp_q.push_back(addr);
    for (int unsigned i = 0; i < n; i++) exp_q.push_back(base + i);
    avs_address = addr; avs_byteenable = be; avs_burstcount = BCW'(n);
    avs_writedata = base; avs_write = 1'b1;
    set_full(0);
    while (beat < n) begin
      @(negedge clk);
      acc = avs_write && !avs_waitrequest;
      if (!avs_waitrequest) begin
        wr_low++;
        if (first_low < 0) first_low = c;
      end
      @(posedge clk); #1;
      c++;
      set_full(c);
      if (acc) begin
        beat++;
        if (abort_after == beat) begin
          rstn = 1'b0; avs_write = 1'b0; req_wrfull = 1'b0;
          #1;
          check("reset_wrreq", 32'(req_wrreq), 32'h0);
          check("reset_waitrequest", 32'(avs_waitrequest), 32'h1);
          check("reset_data", req_data, 32'h0);
          exp_q.delete();
          return;
        end
        if (beat < n) begin
          avs_writedata = base + beat;
          if (int'($urandom_range(99)) < gap_pct) avs_write = 1'b0;
        end else begin
          avs_write = 1'b0;
        end
      end else if (!avs_write) begin
        avs_write = 1'b1;
      end
      if (c > LIMIT) begin
        checks++; errors++;
        $display("FAIL write_timeout: got %0d beats expected %0d", beat, n);
        avs_write = 1'b0;
        return;
      end
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] be, input int unsigned n,
                         output int first_low);
    int c = 0;
    bit acc = 1'b0;
    first_low = -1;
    exp_q.push_back(hdr_word(1'b0, be, n));
    exp_q.push_back(addr);
    avs_address = addr; avs_byteenable = be; avs_burstcount = BCW'(n); avs_read = 1'b1;
    set_full(0);
    while (!acc) begin
      @(negedge clk);
      acc = !avs_waitrequest;
      if (acc) first_low = c;
      @(posedge clk); #1;
      c++;
      set_full(c);
      if (acc) avs_read = 1'b0;
      if (c > LIMIT) begin
        checks++; errors++;
        $display("FAIL read_timeout: got no accept expected accept within %0d cycles", LIMIT);
        avs_read = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b, wl, fl;
    logic [31:0] ref_words[$];

    repeat (3) @(posedge clk);
    #1;
    check("rst_wrreq", 32'(req_wrreq), 32'h0);
    check("rst_data", req_data, 32'h0);
    check("rst_waitrequest", 32'(avs_waitrequest), 32'h1);
    rstn = 1'b1;
    idle(2);
    check("idle_waitrequest", 32'(avs_waitrequest), 32'h1);

    // Single write
    b = got.size();
    do_write(32'h0000_1000, 4'hF, 1, 32'hDEAD_BEEF, 0, 0, wl, fl);
    idle(2);
    check("w1_count", 32'(got.size() - b), 32'd3);
    check("w1_hdr", got[b], 32'h8F00_0001);
    check("w1_addr", got[b+1], 32'h0000_1000);
    check("w1_data", got[b+2], 32'hDEAD_BEEF);
    check("w1_wait_low_cycles", 32'(wl), 32'd1);
    check("w1_wait_low_at", 32'(fl), 32'd3);

    // Read burst of 8
    b = got.size();
    do_read(32'h0000_0020, 4'hF, 8, fl);
    check("r8_wait_after", 32'(avs_waitrequest), 32'h1);
    idle(2);
    check("r8_count", 32'(got.size() - b), 32'd2);
    check("r8_hdr", got[b], 32'h0F00_0008);
    check("r8_addr", got[b+1], 32'h0000_0020);
    check("r8_wait_low_at", 32'(fl), 32'd2);

    // Max burst with gaps
    b = got.size();
    do_write(32'h0000_0100, 4'hF, MAXB, 32'h0, 30, 0, wl, fl);
    idle(2);
    check("w16_count", 32'(got.size() - b), 32'd18);
    check("w16_hdr", got[b], 32'h8F00_0010);
    check("w16_first", got[b+2], 32'h0);
    check("w16_last", got[b+17], 32'd15);
    check("w16_beats_left", 32'(dut.beats_left), 32'h0);
    check("w16_idle_wait", 32'(avs_waitrequest), 32'h1);

    // Burst-4 write without and with stalls in HDR, ADDR and the first DATA beat
    b = got.size();
    do_write(32'h0000_0200, 4'h5, 4, 32'hA000_0000, 0, 0, wl, fl);
    idle(2);
    for (int i = 0; i < 4 + 2; i++) ref_words.push_back(got[b+i]);
    b = got.size();
    full_mode = 1;
    full_pat = 32'h0000_0056;
    do_write(32'h0000_0200, 4'h5, 4, 32'hA000_0000, 0, 0, wl, fl);
    full_mode = 0;
    idle(2);
    check("stall_count", 32'(got.size() - b), 32'd6);
    for (int i = 0; i < 6; i++) check("stall_word", got[b+i], ref_words[i]);
    check("stall_hdr", got[b], 32'h8500_0004);
    check("stall_wait_low_cycles", 32'(wl), 32'd4);
    check("stall_wait_low_at", 32'(fl), 32'd7);

    // Reset during beat 2 of 4, then a read
    b = got.size();
    do_write(32'h0000_0300, 4'hC, 4, 32'h5000_0000, 0, 1, wl, fl);
    repeat (2) @(posedge clk);
    #1;
    check("abort_words", 32'(got.size() - b), 32'd2);
    rstn = 1'b1;
    idle(1);
    b = got.size();
    do_read(32'h0000_0044, 4'h3, 1, fl);
    idle(2);
    check("post_rst_count", 32'(got.size() - b), 32'd2);
    check("post_rst_hdr", got[b], 32'h0300_0001);
    check("post_rst_addr", got[b+1], 32'h0000_0044);

    // Random commands against random FIFO back-pressure
    full_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      int unsigned bc = $urandom_range(MAXB, 1);
      logic [31:0] a = $urandom;
      logic [3:0] be = 4'($urandom);
      if ($urandom_range(1) == 1) do_write(a, be, bc, $urandom, 20, 0, wl, fl);
      else                        do_read(a, be, bc, fl);
    end
    full_mode = 0;
    idle(4);
    check("missing_words", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
